// File: rtl/alu_control_mc.sv
// alu_control_mc: registered ALU control unit with a valid/ready request
// handshake. It decodes {Aluop, funct} into an ALU operation code and
// sequences the multi-cycle MUL operation.
// Optional feature macro: ALU_CTRL_MUL_EN adds MUL decoding and the BUSY
// sequencing (state register and down-counter). When it is undefined,
// every Aluop 11 request is illegal.
module alu_control_mc #(
  parameter int unsigned OP_W      = 4,
  parameter int unsigned MC_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      Aluop,
  input  logic [3:0]      funct,
  output logic [OP_W-1:0] operation,
  output logic            op_valid,
  output logic            busy,
  output logic            illegal
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_XOR = 4'b0011,
    OP_SLL = 4'b0100,
    OP_SRL = 4'b0101,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SRA = 4'b1000,
    OP_MUL = 4'b1001
  } alu_op_e;

  localparam logic [OP_W-1:0] OP_RESET = OP_W'(OP_ADD);

  if (OP_W < 4 || MC_CYCLES < 2) begin : g_param_check
    $error("alu_control_mc: OP_W must be >= 4 and MC_CYCLES must be >= 2");
  end

  alu_op_e         dec_op;
  logic            dec_ill;
  logic            accept;
  logic [OP_W-1:0] op_d;
  logic            opv_d;
  logic            ill_d;

`ifdef ALU_CTRL_MUL_EN
  typedef enum logic {IDLE, BUSY} state_e;

  localparam int unsigned CNT_W = $clog2(MC_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dec_mul;
`endif

  // Decode the request class and function field into an operation code.
  always_comb begin
    dec_op  = OP_ADD;
    dec_ill = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    dec_mul = 1'b0;
`endif
    unique case (Aluop)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (funct)
          4'b0000: dec_op = OP_ADD;
          4'b1000: dec_op = OP_SUB;
          4'b0111: dec_op = OP_AND;
          4'b0110: dec_op = OP_OR;
          4'b0100: dec_op = OP_XOR;
          4'b0001: dec_op = OP_SLL;
          4'b0101: dec_op = OP_SRL;
          4'b1101: dec_op = OP_SRA;
          4'b0010: dec_op = OP_SLT;
          default: dec_ill = 1'b1;
        endcase
      end
      default: begin
`ifdef ALU_CTRL_MUL_EN
        if (funct == 4'b0000) begin
          dec_op  = OP_MUL;
          dec_mul = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
`else
        dec_ill = 1'b1;
`endif
      end
    endcase
  end

`ifdef ALU_CTRL_MUL_EN
  assign in_ready = ~rst & (state_q == IDLE);
  assign busy     = (state_q == BUSY);
`else
  assign in_ready = ~rst;
  assign busy     = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  // Next-state and next-output logic; operation holds unless a legal request is accepted.
  always_comb begin
    op_d  = operation;
    opv_d = 1'b0;
    ill_d = 1'b0;
`ifdef ALU_CTRL_MUL_EN
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (dec_ill) begin
            ill_d = 1'b1;
          end else begin
            op_d = OP_W'(dec_op);
            if (dec_mul) begin
              state_d = BUSY;
              cnt_d   = CNT_W'(MC_CYCLES - 1);
            end else begin
              opv_d = 1'b1;
            end
          end
        end
      end
      BUSY: begin
        // Leaving at a count of 1 keeps the counter from ever reaching 0 in BUSY.
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          opv_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`else
    if (accept) begin
      if (dec_ill) begin
        ill_d = 1'b1;
      end else begin
        op_d  = OP_W'(dec_op);
        opv_d = 1'b1;
      end
    end
`endif
  end

  // Register outputs and sequencing state; synchronous reset aborts any MUL.
  always_ff @(posedge clk) begin
    if (rst) begin
      operation <= OP_RESET;
      op_valid  <= 1'b0;
      illegal   <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
      state_q   <= IDLE;
      cnt_q     <= '0;
`endif
    end else begin
      operation <= op_d;
      op_valid  <= opv_d;
      illegal   <= ill_d;
`ifdef ALU_CTRL_MUL_EN
      state_q   <= state_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// tb_alu_control_mc: directed self-checking bench for alu_control_mc.
// Expected results are queued at request time and popped when the DUT
// reports the outcome. Follows ALU_CTRL_MUL_EN the same way the RTL does.
module tb_alu_control_mc;

  localparam int unsigned OP_W = 4;
  localparam int unsigned MC   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      Aluop;
  logic [3:0]      funct;
  logic [OP_W-1:0] operation;
  logic            op_valid;
  logic            busy;
  logic            illegal;

  typedef struct packed {
    logic       ill;
    logic [3:0] op;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  logic [3:0] model_op;

  alu_control_mc #(.OP_W(OP_W), .MC_CYCLES(MC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Aluop    (Aluop),
    .funct    (funct),
    .operation(operation),
    .op_valid (op_valid),
    .busy     (busy),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode written as an explicit table.
  task automatic ref_dec(input logic [1:0] a, input logic [3:0] f,
                         output logic ill, output logic [3:0] op);
    ill = 1'b0;
    op  = 4'b0010;
    if (a == 2'b00) op = 4'b0010;
    else if (a == 2'b01) op = 4'b0110;
    else if (a == 2'b10) begin
      if      (f == 4'b0000) op = 4'b0010;
      else if (f == 4'b1000) op = 4'b0110;
      else if (f == 4'b0111) op = 4'b0000;
      else if (f == 4'b0110) op = 4'b0001;
      else if (f == 4'b0100) op = 4'b0011;
      else if (f == 4'b0001) op = 4'b0100;
      else if (f == 4'b0101) op = 4'b0101;
      else if (f == 4'b1101) op = 4'b1000;
      else if (f == 4'b0010) op = 4'b0111;
      else ill = 1'b1;
    end else begin
`ifdef ALU_CTRL_MUL_EN
      if (f == 4'b0000) op = 4'b1001;
      else ill = 1'b1;
`else
      ill = 1'b1;
`endif
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl_opv_ill_busy", {31'b0, op_valid & (illegal | busy)}, 32'd0);
  endtask

  task automatic push_req(input logic [1:0] a, input logic [3:0] f);
    logic       ill;
    logic [3:0] op;
    ref_dec(a, f, ill, op);
    if (!ill) model_op = op;
    sb.push_back('{ill: ill, op: model_op});
    in_valid = 1'b1;
    Aluop    = a;
    funct    = f;
  endtask

  task automatic expect_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_opv"}, {31'b0, op_valid}, {31'b0, ~e.ill});
      chk({tag, "_ill"}, {31'b0, illegal}, {31'b0, e.ill});
      chk({tag, "_op"}, 32'(operation), {28'b0, e.op});
    end
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    Aluop    = 2'b00;
    funct    = 4'b0000;
    model_op = 4'b0010;

    tick();
    tick();
    chk("rst_op",    32'(operation), 32'h2);
    chk("rst_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_opv",   {31'b0, op_valid}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_ill",   {31'b0, illegal}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    // Single SUB request
    push_req(2'b10, 4'b1000);
    tick();
    in_valid = 1'b0;
    expect_out("sub");
    tick();
    chk("sub_pulse_end", {31'b0, op_valid}, 32'd0);

    // Back-to-back accepts
    push_req(2'b00, 4'b1111);
    tick();
    expect_out("b2b_ld");
    push_req(2'b01, 4'b1010);
    tick();
    expect_out("b2b_br");
    push_req(2'b10, 4'b0101);
    tick();
    expect_out("b2b_srl");

    // ADD then illegal funct: operation holds
    push_req(2'b00, 4'b0000);
    tick();
    expect_out("add");
    push_req(2'b10, 4'b1111);
    tick();
    in_valid = 1'b0;
    expect_out("ill_funct");
    tick();
    chk("ill_pulse_end", {31'b0, illegal}, 32'd0);
    chk("ill_hold_op",   32'(operation), 32'h2);

    // Sweep every funct for R-type, back to back
    for (int f = 0; f < 16; f++) begin
      push_req(2'b10, 4'(f));
      tick();
      expect_out($sformatf("rtype_f%0d", f));
    end

    // M-extension with non-zero funct is always illegal
    push_req(2'b11, 4'b0001);
    tick();
    in_valid = 1'b0;
    expect_out("m_ill");

`ifdef ALU_CTRL_MUL_EN
    // MUL with an ADD held on the inputs while busy
    tick();
    push_req(2'b11, 4'b0000);
    tick();
    Aluop = 2'b00;
    funct = 4'b0000;
    for (int i = 1; i < int'(MC); i++) begin
      chk($sformatf("mul_busy_c%0d", i),  {31'b0, busy}, 32'd1);
      chk($sformatf("mul_ready_c%0d", i), {31'b0, in_ready}, 32'd0);
      chk($sformatf("mul_opv_c%0d", i),   {31'b0, op_valid}, 32'd0);
      tick();
    end
    expect_out("mul_done");
    chk("mul_done_busy",  {31'b0, busy}, 32'd0);
    chk("mul_done_ready", {31'b0, in_ready}, 32'd1);
    push_req(2'b00, 4'b0000);
    tick();
    in_valid = 1'b0;
    expect_out("add_after_mul");

    // Reset aborts an in-flight MUL
    in_valid = 1'b1;
    Aluop    = 2'b11;
    funct    = 4'b0000;
    tick();
    in_valid = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    chk("abort_op",    32'(operation), 32'h2);
    chk("abort_opv",   {31'b0, op_valid}, 32'd0);
    chk("abort_busy0", {31'b0, busy}, 32'd0);
    chk("abort_ill",   {31'b0, illegal}, 32'd0);
    chk("abort_ready", {31'b0, in_ready}, 32'd0);
    rst      = 1'b0;
    model_op = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("abort_no_opv_%0d", i), {31'b0, op_valid}, 32'd0);
    end
`else
    // Without MUL support, MUL encoding is illegal and never stalls
    push_req(2'b11, 4'b0000);
    tick();
    in_valid = 1'b0;
    expect_out("nomul_ill");
    chk("nomul_busy",  {31'b0, busy}, 32'd0);
    chk("nomul_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("nomul_busy2", {31'b0, busy}, 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_control_mc.md
# alu_control_mc

Registered, parametrised ALU control unit that succeeds the purely combinational decoder. It sits between the main control unit and the ALU. It accepts {Aluop, funct} through a valid/ready handshake and decodes the extended RV32I/M operation set. It sequences multi-cycle operations with a counter-based state machine and raises `busy` so the datapath can stall.

## Interface
- `OP_W`, 4: width of `operation`; must be ≥4; the upper bits are zero-extended.
- `MC_CYCLES`, 4: execution cycles for a multi-cycle operation (MUL); must be ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request; equals ~rst & (state==IDLE).
- `Aluop`  in  2  class from main control: 00 load/store, 01 branch, 10 R-type, 11 M-extension.
- `funct`  in  4  {funct7[5], funct3}.
- `operation`  out  OP_W  registered ALU operation code.
- `op_valid`  out  1  one-cycle pulse; `operation` is final and must be executed.
- `busy`  out  1  multi-cycle operation in progress; the datapath stalls.
- `illegal`  out  1  one-cycle pulse for an undecodable request.

## Operation
- Codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, MUL 1001.
- Aluop 00 decodes to ADD. Aluop 01 decodes to SUB. Both ignore `funct`.
- Aluop 10 funct mapping:
  - 0000 ADD, 1000 SUB, 0111 AND, 0110 OR.
  - 0100 XOR, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT.
  - Any other funct is illegal.
- Aluop 11: funct 0000 decodes to MUL (multi-cycle, see Configuration). Any other funct is illegal.
- FSM states: IDLE, BUSY.
  - IDLE, accept (in_valid & in_ready), single-cycle op: `operation` ← code; `op_valid`=1 next cycle; stay in IDLE.
  - IDLE, accept, MUL: `operation` ← MUL; counter ← MC_CYCLES-1; go to BUSY.
  - IDLE, accept, illegal: `illegal`=1 next cycle; `op_valid`=0; `operation` holds its previous value; stay in IDLE.
  - BUSY: counter decrements each cycle. At counter==1, go to IDLE and `op_valid`=1 in the following cycle. `operation` is held stable throughout.
- `in_valid` while not ready is ignored; the requester must hold the request.
- Reset mid-BUSY aborts the operation. No `op_valid` is issued for it.

## Timing
- Reset values: `operation`=0010 (ADD) zero-extended; `op_valid`=0; `busy`=0; `illegal`=0; state IDLE; counter 0; `in_ready`=0 while `rst`=1.
- Single-cycle op accepted at edge t: `op_valid`/`operation` are visible in cycle t+1. Back-to-back accepts are allowed every cycle.
- MUL accepted at edge t:
  - `busy`=1 for cycles t+1 … t+MC_CYCLES-1.
  - `in_ready`=0 over the same cycles.
  - `op_valid`=1 with `busy`=0 and `in_ready`=1 in cycle t+MC_CYCLES, so a new accept may coincide with completion.
- `illegal` and `op_valid` are never high together. `op_valid` and `busy` are never high together.
- Counter width is $clog2(MC_CYCLES). The counter never wraps below 1 while in BUSY.

## Configuration
- `ALU_CTRL_MUL_EN` defined: Aluop 11/funct 0000 decodes to MUL and uses the BUSY sequence. The counter and BUSY state are present.
- `ALU_CTRL_MUL_EN` undefined:
  - Every Aluop 11 request is illegal.
  - BUSY and the counter are compiled out.
  - `busy` is tied 0 and `in_ready` = ~rst.

## Test plan
- Reset, then Aluop=10/funct=1000 accepted at t: `operation`=0110 and `op_valid`=1 at t+1. During reset: `operation`=0010 and `in_ready`=0.
- Back-to-back accepts of Aluop 00, 01, 10/0101 (three consecutive cycles): `op_valid` high for three cycles with `operation` 0010, 0110, 0101 in that order.
- Aluop=10/funct=1111 after an ADD: `illegal`=1 for one cycle, `op_valid`=0, `operation` stays 0010.
- MUL_EN, MC_CYCLES=4, Aluop=11/0000 accepted at t:
  - `busy`=1 and `in_ready`=0 for cycles t+1..t+3.
  - `op_valid`=1 with `operation`=1001 at t+4.
  - An ADD request held on the inputs is accepted at t+4, and `op_valid` with 0010 follows at t+5.
- MUL accepted, then `rst` asserted at t+2: all outputs return to reset values the next cycle, and no `op_valid` appears for the aborted MUL.
- MUL_EN undefined, Aluop=11/0000: `illegal`=1 at t+1, `busy` stays 0, `in_ready` stays 1.
